// File: rtl/nlc_horner_scheduler_pkg.sv
// Shared types and constants for the NLC Horner scheduler: FSM states,
// operand-select codes and number-format widths.
package nlc_horner_scheduler_pkg;

    localparam int unsigned SMC_W = 32;
    localparam int unsigned FP_W  = 21;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CVI,
        S_NADD,
        S_NMUL,
        S_HMUL,
        S_HADD,
        S_CVO,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_SEL_C5          = 3'd5;
    localparam logic [2:0] OP_SEL_NEG_MEAN    = 3'd6;
    localparam logic [2:0] OP_SEL_RECIP_STDEV = 3'd7;
    localparam logic [2:0] K_START            = 3'd4;

endpackage

// File: rtl/nlc_horner_scheduler_op_timer.sv
// Wait counter shared by all arithmetic-unit waits: flags the issue cycle
// and raises a timeout once the wait exceeds TIMEOUT-1 cycles.
module nlc_horner_scheduler_op_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic issue_o,
    output logic timeout_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at TIMEOUT so a stuck unit cannot wrap the count back to the issue value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign issue_o   = en_i && (cnt_q == '0);
    assign timeout_o = en_i && (cnt_q > CW'(TIMEOUT - 1));

endmodule

// File: rtl/nlc_horner_scheduler.sv
// Sequences the shared fp_to_smc, multiplier, adder and smc_to_fp units to
// normalise and Horner-evaluate NCH ADC channels per frame.
module nlc_horner_scheduler
    import nlc_horner_scheduler_pkg::*;
#(
    parameter int unsigned NCH     = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              srdyi,
    output logic              srdyo,
    output logic              busy_o,
    output logic              err_o,
    output logic [3:0]        ch_sel_o,
    output logic [2:0]        op_sel_o,
    input  logic [SMC_W-1:0]  op_data_i,
    output logic              cvi_srdyi_o,
    input  logic              cvi_srdyo_i,
    input  logic [SMC_W-1:0]  cvi_z_i,
    output logic [SMC_W-1:0]  mul_x_o,
    output logic [SMC_W-1:0]  mul_y_o,
    output logic              mul_srdyi_o,
    input  logic              mul_srdyo_i,
    input  logic [SMC_W-1:0]  mul_z_i,
    output logic [SMC_W-1:0]  add_x_o,
    output logic [SMC_W-1:0]  add_y_o,
    output logic              add_srdyi_o,
    input  logic              add_srdyo_i,
    input  logic [SMC_W-1:0]  add_z_i,
    output logic [SMC_W-1:0]  cvo_x_o,
    output logic              cvo_srdyi_o,
    input  logic              cvo_srdyo_i,
    input  logic [FP_W-1:0]   cvo_y_i,
    output logic              res_we_o,
    output logic [3:0]        res_ch_o,
    output logic [FP_W-1:0]   res_data_o
);

    state_t            state_q, state_d;
    logic [3:0]        ch_q, ch_d;
    logic [2:0]        k_q, k_d;
    logic [SMC_W-1:0]  xs_q, xs_d, xn_q, xn_d, acc_q, acc_d;
    logic [FP_W-1:0]   res_q, res_d;
    logic              err_q, err_d;
    logic              in_op, unit_done, issue, timeout, t_clr;

    assign in_op  = state_q inside {S_CVI, S_NADD, S_NMUL, S_HMUL, S_HADD, S_CVO};
    assign t_clr  = (state_d != state_q);
    assign busy_o = (state_q != S_IDLE);
    assign err_o  = err_q;

    nlc_horner_scheduler_op_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .en_i      (in_op),
        .clr_i     (t_clr),
        .issue_o   (issue),
        .timeout_o (timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            k_q     <= '0;
            xs_q    <= '0;
            xn_q    <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            k_q     <= k_d;
            xs_q    <= xs_d;
            xn_q    <= xn_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        k_d         = k_q;
        xs_d        = xs_q;
        xn_d        = xn_q;
        acc_d       = acc_q;
        res_d       = res_q;
        err_d       = err_q;
        unit_done   = 1'b0;
        srdyo       = 1'b0;
        ch_sel_o    = ch_q;
        op_sel_o    = '0;
        cvi_srdyi_o = 1'b0;
        mul_x_o     = '0;
        mul_y_o     = '0;
        mul_srdyi_o = 1'b0;
        add_x_o     = '0;
        add_y_o     = '0;
        add_srdyi_o = 1'b0;
        cvo_x_o     = '0;
        cvo_srdyi_o = 1'b0;
        res_we_o    = 1'b0;
        res_ch_o    = '0;
        res_data_o  = '0;

        case (state_q)
            S_IDLE: begin
                if (srdyi) begin
                    state_d = S_CVI;
                    ch_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_CVI: begin
                cvi_srdyi_o = issue;
                unit_done   = cvi_srdyo_i;
                if (unit_done) begin
                    xs_d    = cvi_z_i;
                    state_d = S_NADD;
                end
            end
            S_NADD: begin
                op_sel_o    = OP_SEL_NEG_MEAN;
                add_x_o     = xs_q;
                add_y_o     = op_data_i;
                add_srdyi_o = issue;
                unit_done   = add_srdyo_i;
                if (unit_done) begin
                    xs_d    = add_z_i;
                    state_d = S_NMUL;
                end
            end
            S_NMUL: begin
                op_sel_o    = OP_SEL_RECIP_STDEV;
                mul_x_o     = xs_q;
                mul_y_o     = op_data_i;
                mul_srdyi_o = issue;
                unit_done   = mul_srdyo_i;
                if (unit_done) begin
                    xn_d    = mul_z_i;
                    k_d     = K_START;
                    state_d = S_HMUL;
                end
            end
            S_HMUL: begin
                // On the first pass the accumulator is c5, read straight from the operand mux.
                op_sel_o    = OP_SEL_C5;
                mul_x_o     = (k_q == K_START) ? op_data_i : acc_q;
                mul_y_o     = xn_q;
                mul_srdyi_o = issue;
                unit_done   = mul_srdyo_i;
                if (unit_done) begin
                    acc_d   = mul_z_i;
                    state_d = S_HADD;
                end
            end
            S_HADD: begin
                op_sel_o    = k_q;
                add_x_o     = acc_q;
                add_y_o     = op_data_i;
                add_srdyi_o = issue;
                unit_done   = add_srdyo_i;
                if (unit_done) begin
                    acc_d = add_z_i;
                    if (k_q == '0) begin
                        state_d = S_CVO;
                    end else begin
                        k_d     = k_q - 3'd1;
                        state_d = S_HMUL;
                    end
                end
            end
            S_CVO: begin
                cvo_x_o     = acc_q;
                cvo_srdyi_o = issue;
                unit_done   = cvo_srdyo_i;
                if (unit_done) begin
                    res_d   = cvo_y_i;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                res_we_o   = 1'b1;
                res_ch_o   = ch_q;
                res_data_o = res_q;
                if (ch_q == 4'(NCH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + 4'd1;
                    state_d = S_CVI;
                end
            end
            S_DONE: begin
                srdyo   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (in_op && !unit_done && timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end

endmodule

// File: tb/tb_nlc_horner_scheduler.sv
// Scoreboard bench for nlc_horner_scheduler: latency-2 unit models, a Horner
// reference model and a monitor that checks every result write.
module tb_nlc_horner_scheduler;

    localparam int NCH     = 16;
    localparam int TIMEOUT = 64;
    localparam int L       = 2;
    localparam int FRAME   = NCH * (14 * (L + 1) + 1) + 1;
    localparam logic [31:0] ONE = 32'h0001_0000;

    typedef struct packed {
        logic [3:0]  ch;
        logic [20:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, srdyi, srdyo, busy_o, err_o;
    logic [3:0]  ch_sel_o, res_ch_o;
    logic [2:0]  op_sel_o;
    logic [31:0] op_data_i, cvi_z_i, mul_x_o, mul_y_o, mul_z_i, add_x_o, add_y_o, add_z_i, cvo_x_o;
    logic        cvi_srdyi_o, cvi_srdyo_i, mul_srdyi_o, mul_srdyo_i, add_srdyi_o, add_srdyo_i;
    logic        cvo_srdyi_o, cvo_srdyo_i, res_we_o;
    logic [20:0] cvo_y_i, res_data_o;

    logic [31:0] x_adc [NCH];
    logic [31:0] opv   [NCH][8];
    logic        mul_hang;
    logic [1:0]  cvi_sr, mul_sr, add_sr, cvo_sr;

    exp_t sb[$];
    int   total = 0, bad = 0;
    int   cyc = 0, we_cnt = 0, srdyo_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nlc_horner_scheduler #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .srdyi(srdyi), .srdyo(srdyo), .busy_o(busy_o), .err_o(err_o),
        .ch_sel_o(ch_sel_o), .op_sel_o(op_sel_o), .op_data_i(op_data_i),
        .cvi_srdyi_o(cvi_srdyi_o), .cvi_srdyo_i(cvi_srdyo_i), .cvi_z_i(cvi_z_i),
        .mul_x_o(mul_x_o), .mul_y_o(mul_y_o), .mul_srdyi_o(mul_srdyi_o), .mul_srdyo_i(mul_srdyo_i), .mul_z_i(mul_z_i),
        .add_x_o(add_x_o), .add_y_o(add_y_o), .add_srdyi_o(add_srdyi_o), .add_srdyo_i(add_srdyo_i), .add_z_i(add_z_i),
        .cvo_x_o(cvo_x_o), .cvo_srdyi_o(cvo_srdyi_o), .cvo_srdyo_i(cvo_srdyo_i), .cvo_y_i(cvo_y_i),
        .res_we_o(res_we_o), .res_ch_o(res_ch_o), .res_data_o(res_data_o)
    );

    // Q16.16 fixed point stands in for smc; fp is the top 21 bits.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed(a) * $signed(b);
        return p[47:16];
    endfunction

    function automatic logic [20:0] to_fp(input logic [31:0] a);
        return a[31:11];
    endfunction

    function automatic logic [20:0] ref_ch(input int ch);
        logic [31:0] xn, acc;
        xn  = fmul(x_adc[ch] + opv[ch][6], opv[ch][7]);
        acc = opv[ch][5];
        for (int k = 4; k >= 0; k--) acc = fmul(acc, xn) + opv[ch][k];
        return to_fp(acc);
    endfunction

    assign op_data_i   = opv[ch_sel_o][op_sel_o];
    assign cvi_srdyo_i = cvi_sr[L-1];
    assign mul_srdyo_i = mul_sr[L-1] && !mul_hang;
    assign add_srdyo_i = add_sr[L-1];
    assign cvo_srdyo_i = cvo_sr[L-1];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cvi_sr <= '0; mul_sr <= '0; add_sr <= '0; cvo_sr <= '0;
            cvi_z_i <= '0; mul_z_i <= '0; add_z_i <= '0; cvo_y_i <= '0;
        end else begin
            cvi_sr <= {cvi_sr[0], cvi_srdyi_o};
            mul_sr <= {mul_sr[0], mul_srdyi_o};
            add_sr <= {add_sr[0], add_srdyi_o};
            cvo_sr <= {cvo_sr[0], cvo_srdyi_o};
            if (cvi_srdyi_o) cvi_z_i <= x_adc[ch_sel_o];
            if (mul_srdyi_o) mul_z_i <= fmul(mul_x_o, mul_y_o);
            if (add_srdyi_o) add_z_i <= add_x_o + add_y_o;
            if (cvo_srdyi_o) cvo_y_i <= to_fp(cvo_x_o);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (res_we_o) begin
            we_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_res_we", {60'd0, res_ch_o}, 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_ch", res_ch_o, e.ch);
                chk("res_data", res_data_o, e.d);
            end
        end
        if (srdyo) srdyo_cnt++;
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, {srdyo, busy_o, err_o, res_we_o, cvi_srdyi_o, mul_srdyi_o, add_srdyi_o, cvo_srdyi_o}, 0);
        chk({tag, "_sel"}, {ch_sel_o, op_sel_o}, 0);
        chk({tag, "_data"}, mul_x_o | mul_y_o | add_x_o | add_y_o | cvo_x_o, 0);
        chk({tag, "_res"}, {res_ch_o, res_data_o}, 0);
    endtask

    // mode 0: random operands / reference model; 1: only c0=1.0; 2: identity polynomial
    task automatic load(input int mode);
        for (int c = 0; c < NCH; c++) begin
            x_adc[c] = $urandom;
            for (int s = 0; s < 8; s++) opv[c][s] = (mode == 0) ? $urandom : 32'd0;
            if (mode == 0) begin
                opv[c][7] = $urandom_range(32'h0002_0000, 0);
                for (int s = 0; s < 6; s++) opv[c][s] = $urandom_range(32'h0004_0000, 0) - 32'h0002_0000;
            end
            if (mode == 1) opv[c][0] = ONE;
            if (mode == 2) begin
                opv[c][1] = ONE;
                opv[c][7] = ONE;
            end
        end
    endtask

    task automatic push_exp(input int mode);
        for (int c = 0; c < NCH; c++) begin
            exp_t e;
            e.ch = 4'(c);
            if (mode == 1)      e.d = 21'h20;
            else if (mode == 2) e.d = x_adc[c][31:11];
            else                e.d = ref_ch(c);
            sb.push_back(e);
        end
    endtask

    task automatic accept(output int at);
        @(negedge clk);
        srdyi = 1'b1;
        at = cyc;
        @(negedge clk);
        srdyi = 1'b0;
    endtask

    task automatic wait_srdyo(input int budget, output bit seen, output int at);
        seen = 1'b0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (srdyo) begin
                seen = 1'b1;
                at = cyc;
                return;
            end
        end
    endtask

    task automatic run_frame(input string tag, input int mode, input bit poke);
        int a, d, s0;
        bit seen;
        load(mode);
        push_exp(mode);
        we_cnt = 0;
        s0 = srdyo_cnt;
        accept(a);
        chk({tag, "_busy_start"}, busy_o, 1);
        chk({tag, "_err_clear"}, err_o, 0);
        if (poke) begin
            repeat (300) @(negedge clk);
            srdyi = 1'b1;
            @(negedge clk);
            srdyi = 1'b0;
        end
        wait_srdyo(2 * FRAME, seen, d);
        chk({tag, "_srdyo_seen"}, seen, 1);
        chk({tag, "_latency"}, d - a, FRAME);
        chk({tag, "_busy_done"}, busy_o, 1);
        if (poke) srdyi = 1'b1;
        @(negedge clk);
        srdyi = 1'b0;
        chk({tag, "_busy_idle"}, busy_o, 0);
        if (poke) repeat (60) @(negedge clk);
        chk({tag, "_we_count"}, we_cnt, NCH);
        chk({tag, "_srdyo_count"}, srdyo_cnt - s0, 1);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        int a, t_iss, t_err, s0, n, iss_pulses;
        bit found;
        reset = 1'b1;
        srdyi = 1'b0;
        mul_hang = 1'b0;
        load(0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        run_frame("rand0", 0, 1'b0);
        run_frame("c0only", 1, 1'b0);
        run_frame("ident", 2, 1'b1);
        run_frame("rand1", 0, 1'b0);

        // multiplier stalls: timeout counted from the issue cycle (count 0) until it exceeds TIMEOUT-1
        load(0);
        mul_hang = 1'b1;
        s0 = srdyo_cnt;
        we_cnt = 0;
        accept(a);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (mul_srdyi_o) begin
                found = 1'b1;
                t_iss = cyc;
            end else @(negedge clk);
        end
        chk("tmo_mul_issued", found, 1);
        found = 1'b0;
        iss_pulses = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (mul_srdyi_o) iss_pulses++;
            @(negedge clk);
            if (err_o) begin
                found = 1'b1;
                t_err = cyc;
            end
        end
        chk("tmo_err_seen", found, 1);
        chk("tmo_err_delay", t_err - t_iss, TIMEOUT + 1);
        chk("tmo_issue_pulses", iss_pulses, 1);
        chk("tmo_busy_low", busy_o, 0);
        repeat (20) @(negedge clk);
        chk("tmo_err_sticky", err_o, 1);
        chk("tmo_no_srdyo", srdyo_cnt - s0, 0);
        chk("tmo_no_we", we_cnt, 0);
        mul_hang = 1'b0;

        run_frame("after_tmo", 0, 1'b0);

        // reset during channel 7's first Horner multiply
        load(0);
        push_exp(0);
        we_cnt = 0;
        s0 = srdyo_cnt;
        accept(a);
        n = 0;
        for (int i = 0; i < 2 * FRAME && n < 2; i++) begin
            @(negedge clk);
            if (mul_srdyi_o && ch_sel_o == 4'd7) n++;
        end
        chk("rst7_reached", n, 2);
        reset = 1'b1;
        #1;
        check_all_zero("rst7");
        @(negedge clk);
        check_all_zero("rst7_hold");
        reset = 1'b0;
        sb.delete();
        chk("rst7_partial_we", we_cnt, 7);
        repeat (50) @(negedge clk);
        chk("rst7_no_srdyo", srdyo_cnt - s0, 0);
        chk("rst7_idle", busy_o, 0);

        run_frame("post_rst", 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
